// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : MIPS data memory with lane-selected loads, byte/half/word stores,
//               access-fault detection and a registered last-store record.
// Revision    : 1.0
// ============================================================================
module data_mem #(
   parameter int DEPTH_WORDS = 3072,
   parameter int AW          = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [2:0]  MemOp,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Exc,
   output logic        StValid,
   output logic [31:0] StAddr,
   output logic [31:0] StData
);

   localparam logic [2:0]  c_OP_W  = 3'b000;
   localparam logic [2:0]  c_OP_H  = 3'b001;
   localparam logic [2:0]  c_OP_HU = 3'b010;
   localparam logic [2:0]  c_OP_B  = 3'b011;
   localparam logic [2:0]  c_OP_BU = 3'b100;
   localparam logic [31:0] c_BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

   logic [31:0]   r_mem [0:DEPTH_WORDS-1];
   logic          r_st_valid;
   logic [31:0]   r_st_addr;
   logic [31:0]   r_st_data;

   logic [AW-1:0] w_index;
   logic          w_in_range;
   logic          w_illegal_op;
   logic          w_misaligned;
   logic          w_exc;
   logic [31:0]   w_rword;
   logic [15:0]   w_half;
   logic [7:0]    w_byte;
   logic [31:0]   w_load;
   logic [3:0]    w_byte_we;
   logic [31:0]   w_wdata;
   logic [31:0]   w_merged;
   logic          w_commit;

   assign w_index    = Addr[AW+1:2];
   // Full 32-bit compare so high address bits can never alias onto a low word.
   assign w_in_range = (Addr < c_BYTE_LIMIT);

   // Unsigned load encodings have no store counterpart.
   always_comb begin
      w_illegal_op = 1'b0;
      case (MemOp)
         c_OP_W, c_OP_H, c_OP_B: w_illegal_op = 1'b0;
         c_OP_HU, c_OP_BU:       w_illegal_op = MemWrite;
         default:                w_illegal_op = 1'b1;
      endcase
   end

   always_comb begin
      w_misaligned = 1'b0;
      case (MemOp)
         c_OP_W:          w_misaligned = (Addr[1:0] != 2'b00);
         c_OP_H, c_OP_HU: w_misaligned = Addr[0];
         default:         w_misaligned = 1'b0;
      endcase
   end

   assign w_exc    = w_illegal_op | ~w_in_range | w_misaligned;
   assign w_commit = MemWrite & ~w_exc & ~reset;

   assign w_rword = w_in_range ? r_mem[w_index] : 32'h0;
   assign w_half  = Addr[1] ? w_rword[31:16] : w_rword[15:0];
   assign w_byte  = w_rword[8*Addr[1:0] +: 8];

   always_comb begin
      w_load = 32'h0;
      case (MemOp)
         c_OP_W:  w_load = w_rword;
         c_OP_H:  w_load = {{16{w_half[15]}}, w_half};
         c_OP_HU: w_load = {16'h0, w_half};
         c_OP_B:  w_load = {{24{w_byte[7]}}, w_byte};
         c_OP_BU: w_load = {24'h0, w_byte};
         default: w_load = 32'h0;
      endcase
   end

   assign RD  = w_exc ? 32'h0 : w_load;
   assign Exc = w_exc;

   // Store data is replicated across lanes; byte enables pick the live lane(s).
   always_comb begin
      w_byte_we = 4'b0000;
      w_wdata   = WD;
      case (MemOp)
         c_OP_W: begin
            w_byte_we = 4'b1111;
            w_wdata   = WD;
         end
         c_OP_H: begin
            w_byte_we = Addr[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {WD[15:0], WD[15:0]};
         end
         c_OP_B: begin
            w_byte_we = 4'b0001 << Addr[1:0];
            w_wdata   = {4{WD[7:0]}};
         end
         default: begin
            w_byte_we = 4'b0000;
            w_wdata   = WD;
         end
      endcase
   end

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_merged[8*k +: 8] = w_byte_we[k] ? w_wdata[8*k +: 8] : w_rword[8*k +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= 32'h0;
         end
         r_st_valid <= 1'b0;
         r_st_addr  <= 32'h0;
         r_st_data  <= 32'h0;
      end else if (w_commit) begin
         r_mem[w_index] <= w_merged;
         r_st_valid     <= 1'b1;
         r_st_addr      <= {Addr[31:2], 2'b00};
         r_st_data      <= w_merged;
      end else begin
         r_st_valid <= 1'b0;
      end
   end

   assign StValid = r_st_valid;
   assign StAddr  = r_st_addr;
   assign StData  = r_st_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem
// Description : Directed self-checking bench for data_mem.
// Revision    : 1.0
// ============================================================================
module tb_data_mem;

   localparam logic [2:0] c_W  = 3'b000;
   localparam logic [2:0] c_H  = 3'b001;
   localparam logic [2:0] c_HU = 3'b010;
   localparam logic [2:0] c_B  = 3'b011;
   localparam logic [2:0] c_BU = 3'b100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [2:0]  MemOp = 3'b000;
   logic [31:0] Addr = 32'h0;
   logic [31:0] WD = 32'h0;
   logic [31:0] RD;
   logic        Exc;
   logic        StValid;
   logic [31:0] StAddr;
   logic [31:0] StData;

   int checks = 0;
   int errors = 0;

   data_mem dut (
      .clk      (clk),
      .reset    (reset),
      .MemWrite (MemWrite),
      .MemOp    (MemOp),
      .Addr     (Addr),
      .WD       (WD),
      .RD       (RD),
      .Exc      (Exc),
      .StValid  (StValid),
      .StAddr   (StAddr),
      .StData   (StData)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are observed 1 ns later.
   task automatic op(input logic rst, input logic we, input logic [2:0] mop,
                     input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      reset = rst; MemWrite = we; MemOp = mop; Addr = a; WD = d;
      #1;
   endtask

   task automatic test_reset;
      op(1'b1, 1'b0, c_W, 32'h0, 32'h0);
      op(1'b0, 1'b0, c_W, 32'h0, 32'h0);
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd0 got %h exp %h", RD, 32'h0); end
      checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", Exc); end
      checks++; if (StValid !== 1'b0) begin errors++; $display("FAIL reset_stvalid got %b exp 0", StValid); end
      checks++; if (StAddr !== 32'h0 || StData !== 32'h0) begin errors++; $display("FAIL reset_strec got %h/%h exp 0/0", StAddr, StData); end
      op(1'b0, 1'b0, c_W, 32'h2FFC, 32'h0);
      checks++; if (RD !== 32'h0 || Exc !== 1'b0) begin errors++; $display("FAIL reset_rdtop got %h exc %b exp 0 exc 0", RD, Exc); end
   endtask

   task automatic test_word;
      op(1'b0, 1'b1, c_W, 32'h10, 32'h12345678);
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rdw_old got %h exp %h", RD, 32'h0); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'h12345678) begin errors++; $display("FAIL sw_lw got %h exp %h", RD, 32'h12345678); end
      checks++; if (StValid !== 1'b1) begin errors++; $display("FAIL sw_stvalid got %b exp 1", StValid); end
      checks++; if (StAddr !== 32'h10) begin errors++; $display("FAIL sw_staddr got %h exp %h", StAddr, 32'h10); end
      checks++; if (StData !== 32'h12345678) begin errors++; $display("FAIL sw_stdata got %h exp %h", StData, 32'h12345678); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (StValid !== 1'b0 || StAddr !== 32'h10) begin errors++; $display("FAIL st_hold got %b/%h exp 0/%h", StValid, StAddr, 32'h10); end
   endtask

   task automatic test_lanes;
      op(1'b0, 1'b1, c_B, 32'h11, 32'h000000AB);
      op(1'b0, 1'b1, c_H, 32'h12, 32'h0000FFEE);
      checks++; if (StData !== 32'h1234AB78 || StAddr !== 32'h10) begin errors++; $display("FAIL sb_stdata got %h@%h exp %h@%h", StData, StAddr, 32'h1234AB78, 32'h10); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'hFFEEAB78) begin errors++; $display("FAIL lanes_lw got %h exp %h", RD, 32'hFFEEAB78); end
      checks++; if (StData !== 32'hFFEEAB78 || StAddr !== 32'h10) begin errors++; $display("FAIL sh_stdata got %h@%h exp %h@%h", StData, StAddr, 32'hFFEEAB78, 32'h10); end
      op(1'b0, 1'b0, c_B, 32'h11, 32'h0);
      checks++; if (RD !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb got %h exp %h", RD, 32'hFFFFFFAB); end
      op(1'b0, 1'b0, c_BU, 32'h11, 32'h0);
      checks++; if (RD !== 32'h000000AB) begin errors++; $display("FAIL lbu got %h exp %h", RD, 32'h000000AB); end
      op(1'b0, 1'b0, c_H, 32'h12, 32'h0);
      checks++; if (RD !== 32'hFFFFFFEE) begin errors++; $display("FAIL lh got %h exp %h", RD, 32'hFFFFFFEE); end
      op(1'b0, 1'b0, c_HU, 32'h12, 32'h0);
      checks++; if (RD !== 32'h0000FFEE) begin errors++; $display("FAIL lhu got %h exp %h", RD, 32'h0000FFEE); end
      op(1'b0, 1'b0, c_B, 32'h10, 32'h0);
      checks++; if (RD !== 32'h00000078) begin errors++; $display("FAIL lb_pos got %h exp %h", RD, 32'h00000078); end
      op(1'b0, 1'b0, c_H, 32'h10, 32'h0);
      checks++; if (RD !== 32'hFFFFAB78) begin errors++; $display("FAIL lh_low got %h exp %h", RD, 32'hFFFFAB78); end
      op(1'b0, 1'b0, c_B, 32'h13, 32'h0);
      checks++; if (RD !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_top got %h exp %h", RD, 32'hFFFFFFFF); end
   endtask

   task automatic test_faults;
      op(1'b0, 1'b0, c_W, 32'h2, 32'h0);
      checks++; if (Exc !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL lw_misal got exc %b rd %h exp 1/0", Exc, RD); end
      op(1'b0, 1'b0, c_H, 32'h11, 32'h0);
      checks++; if (Exc !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL lh_misal got exc %b rd %h exp 1/0", Exc, RD); end
      op(1'b0, 1'b1, c_H, 32'h13, 32'h00001111);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL sh_misal got %b exp 1", Exc); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'hFFEEAB78 || StValid !== 1'b0) begin errors++; $display("FAIL sh_misal_nochg got %h/%b exp %h/0", RD, StValid, 32'hFFEEAB78); end
      op(1'b0, 1'b1, c_W, 32'h3000, 32'hDEADBEEF);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL sw_range got %b exp 1", Exc); end
      op(1'b0, 1'b0, 3'b111, 32'h10, 32'h0);
      checks++; if (Exc !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL op111 got exc %b rd %h exp 1/0", Exc, RD); end
      op(1'b0, 1'b0, 3'b101, 32'h10, 32'h0);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL op101 got %b exp 1", Exc); end
      op(1'b0, 1'b1, c_HU, 32'h10, 32'h00000000);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL store_hu got %b exp 1", Exc); end
      op(1'b0, 1'b1, c_BU, 32'h10, 32'h00000000);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL store_bu got %b exp 1", Exc); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'hFFEEAB78 || StValid !== 1'b0) begin errors++; $display("FAIL illegal_nochg got %h/%b exp %h/0", RD, StValid, 32'hFFEEAB78); end
   endtask

   task automatic test_boundary;
      op(1'b0, 1'b1, c_W, 32'h2FFC, 32'hCAFEBABE);
      checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL sw_top_exc got %b exp 0", Exc); end
      op(1'b0, 1'b0, c_W, 32'h2FFC, 32'h0);
      checks++; if (RD !== 32'hCAFEBABE) begin errors++; $display("FAIL lw_top got %h exp %h", RD, 32'hCAFEBABE); end
      op(1'b0, 1'b0, c_B, 32'h2FFF, 32'h0);
      checks++; if (RD !== 32'hFFFFFFCA || Exc !== 1'b0) begin errors++; $display("FAIL lb_lastbyte got %h exc %b exp %h/0", RD, Exc, 32'hFFFFFFCA); end
      op(1'b0, 1'b0, c_W, 32'h3000, 32'h0);
      checks++; if (Exc !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL lw_3000 got exc %b rd %h exp 1/0", Exc, RD); end
      op(1'b0, 1'b1, c_W, 32'hFFFFFFFC, 32'h0BADF00D);
      checks++; if (Exc !== 1'b1 || RD !== 32'h0) begin errors++; $display("FAIL sw_high got exc %b rd %h exp 1/0", Exc, RD); end
      op(1'b0, 1'b1, c_W, 32'h80000010, 32'h0BADF00D);
      checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL sw_alias got %b exp 1", Exc); end
      op(1'b0, 1'b1, c_W, 32'h00004010, 32'h0BADF00D);
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'hFFEEAB78) begin errors++; $display("FAIL alias_low got %h exp %h", RD, 32'hFFEEAB78); end
      op(1'b0, 1'b0, c_W, 32'h2FFC, 32'h0);
      checks++; if (RD !== 32'hCAFEBABE) begin errors++; $display("FAIL alias_top got %h exp %h", RD, 32'hCAFEBABE); end
   endtask

   task automatic test_back_to_back;
      op(1'b0, 1'b1, c_B, 32'h40, 32'hFFFFFF11);
      op(1'b0, 1'b1, c_B, 32'h41, 32'h00000022);
      op(1'b0, 1'b1, c_B, 32'h42, 32'h00000033);
      op(1'b0, 1'b1, c_B, 32'h43, 32'h00000044);
      checks++; if (RD !== 32'h0 || StData !== 32'h00332211 || StValid !== 1'b1) begin errors++; $display("FAIL b2b_mid got rd %h st %h v %b exp 0/%h/1", RD, StData, StValid, 32'h00332211); end
      op(1'b0, 1'b0, c_W, 32'h40, 32'h0);
      checks++; if (RD !== 32'h44332211) begin errors++; $display("FAIL b2b_lw got %h exp %h", RD, 32'h44332211); end
      checks++; if (StAddr !== 32'h40 || StData !== 32'h44332211) begin errors++; $display("FAIL b2b_strec got %h@%h exp %h@%h", StData, StAddr, 32'h44332211, 32'h40); end
   endtask

   task automatic test_reset_store;
      op(1'b1, 1'b1, c_W, 32'h20, 32'h00000001);
      op(1'b0, 1'b0, c_W, 32'h20, 32'h0);
      checks++; if (RD !== 32'h0 || StValid !== 1'b0) begin errors++; $display("FAIL rst_store got %h/%b exp 0/0", RD, StValid); end
      checks++; if (StAddr !== 32'h0 || StData !== 32'h0) begin errors++; $display("FAIL rst_strec got %h/%h exp 0/0", StAddr, StData); end
      op(1'b0, 1'b0, c_W, 32'h10, 32'h0);
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rst_clr10 got %h exp 0", RD); end
      op(1'b0, 1'b0, c_W, 32'h2FFC, 32'h0);
      checks++; if (RD !== 32'h0) begin errors++; $display("FAIL rst_clrtop got %h exp 0", RD); end
      op(1'b0, 1'b1, c_W, 32'h22, 32'h00000001);
      op(1'b0, 1'b1, c_W, 32'h20, 32'h00000055);
      op(1'b0, 1'b0, c_W, 32'h20, 32'h0);
      checks++; if (RD !== 32'h00000055 || StValid !== 1'b1 || StAddr !== 32'h20) begin errors++; $display("FAIL post_rst_sw got %h/%b/%h exp %h/1/%h", RD, StValid, StAddr, 32'h55, 32'h20); end
   endtask

   initial begin
      test_reset;
      test_word;
      test_lanes;
      test_faults;
      test_boundary;
      test_back_to_back;
      test_reset_store;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
